// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types, widths and slot search for the digit scanner
// BLANK_GAP_EN adds the BLANK state to the state enum.
package display_pkg;

   localparam int SLOT_W    = 3;
   localparam int VAL_W     = 4;
   localparam int MAX_SLOTS = 2 ** SLOT_W;

   typedef enum logic [1:0] {
      IDLE,
      SHOW
`ifdef BLANK_GAP_EN
      , BLANK
`endif
   } scan_state_e;

   // Circular ascending search starting just above cur; returns cur when it is the only enabled slot.
   function automatic logic [SLOT_W-1:0] next_enabled_slot(
      input logic [MAX_SLOTS-1:0] mask,
      input logic [SLOT_W-1:0]    cur,
      input int                   num_slots
   );
      logic [SLOT_W-1:0] res;
      logic              found;
      int                idx;
      res   = cur;
      found = 1'b0;
      for (int k = 1; k <= MAX_SLOTS; k++) begin
         if (k <= num_slots && !found) begin
            idx = int'(cur) + k;
            if (idx >= num_slots) idx = idx - num_slots;
            if (mask[idx[SLOT_W-1:0]]) begin
               res   = idx[SLOT_W-1:0];
               found = 1'b1;
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// rtl/scan_tick_gen.sv - free-running prescaler with sync clear, one-cycle tick every DIV cycles
module scan_tick_gen #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int           W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + W'(1);
      end
   end

   assign tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - double-buffered 7-seg slot scanner driving AN/D
// Define BLANK_GAP_EN to insert a BLANK_CYC-cycle dark gap after each slot.
module display_scan_ctrl
   import display_pkg::*;
#(
   parameter int NUM_SLOTS = 6,
   parameter int AN_W      = SLOT_W,
   parameter int D_W       = VAL_W,
   parameter int DIV       = 100000,
   parameter int BLANK_CYC = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [AN_W-1:0]      wr_slot,
   input  logic [D_W-1:0]       wr_data,
   input  logic [NUM_SLOTS-1:0] slot_mask,
   output logic [AN_W-1:0]      AN,
   output logic [D_W-1:0]       D,
   output logic                 valid,
   output logic                 frame_done
);

   localparam logic [AN_W:0] SLOT_LIMIT = (AN_W + 1)'(NUM_SLOTS);

   scan_state_e     state, state_nx;
   logic [AN_W-1:0] slot_nx, adv_slot, first_slot;
   logic [D_W-1:0]  d_nx;
   logic [D_W-1:0]  shadow [NUM_SLOTS];
   logic [D_W-1:0]  active [NUM_SLOTS];
   logic            load, fd_nx, adv_wrap;
   logic            show_tick, show_clr;

   assign show_clr = (state != SHOW) || (slot_mask == '0);

   scan_tick_gen #(.DIV(DIV)) u_show_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (show_clr),
      .tick (show_tick)
   );

`ifdef BLANK_GAP_EN
   logic blank_tick;

   scan_tick_gen #(.DIV(BLANK_CYC)) u_blank_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (state != BLANK),
      .tick (blank_tick)
   );
`endif

   assign adv_slot   = AN_W'(next_enabled_slot(MAX_SLOTS'(slot_mask), SLOT_W'(AN), NUM_SLOTS));
   assign first_slot = AN_W'(next_enabled_slot(MAX_SLOTS'(slot_mask), SLOT_W'(NUM_SLOTS - 1), NUM_SLOTS));
   assign adv_wrap   = (adv_slot <= AN);

   always_comb begin
      state_nx = state;
      slot_nx  = AN;
      load     = 1'b0;
      fd_nx    = 1'b0;
      d_nx     = '0;
      if (slot_mask == '0) begin
         state_nx = IDLE;
         slot_nx  = '0;
      end else begin
         case (state)
            IDLE: begin
               state_nx = SHOW;
               slot_nx  = first_slot;
               load     = 1'b1;
            end
            SHOW: begin
               if (show_tick) begin
`ifdef BLANK_GAP_EN
                  state_nx = BLANK;
`else
                  slot_nx = adv_slot;
                  load    = adv_wrap;
                  fd_nx   = adv_wrap;
`endif
               end
            end
`ifdef BLANK_GAP_EN
            BLANK: begin
               if (blank_tick) begin
                  state_nx = SHOW;
                  slot_nx  = adv_slot;
                  load     = adv_wrap;
                  fd_nx    = adv_wrap;
               end
            end
`endif
            default: begin
               state_nx = IDLE;
               slot_nx  = '0;
            end
         endcase
      end
      // On a frame load the new slot must show the buffer being loaded, not the stale one.
      if (state_nx == SHOW) begin
         d_nx = load ? shadow[slot_nx] : active[slot_nx];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         AN         <= '0;
         D          <= '0;
         valid      <= 1'b0;
         frame_done <= 1'b0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         state      <= state_nx;
         AN         <= slot_nx;
         D          <= d_nx;
         valid      <= (state_nx == SHOW);
         frame_done <= fd_nx;
         if (load) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
               active[i] <= shadow[i];
            end
         end
         if (wr_en && ({1'b0, wr_slot} < SLOT_LIMIT)) begin
            shadow[wr_slot] <= wr_data;
         end
      end
   end

endmodule
